// File: rtl/vram_pkg.sv
// Shared constants, state encoding and helpers for the VRAM
// byte-stream writer.
package vram_pkg;

  localparam int unsigned VRAM_WORDS = 600;
  localparam int unsigned VRAM_AW    = 10;
  localparam int unsigned VRAM_DW    = 16;

  localparam logic [7:0] SYNC_WRITE = 8'hA5;
  localparam logic [7:0] SYNC_FILL  = 8'h5A;

  typedef enum logic [3:0] {
    IDLE,
    W_AH,
    W_AL,
    W_DH,
    W_DL,
    F_DH,
    F_DL,
    FILL
  } wr_state_t;

  function automatic logic mid_frame(wr_state_t s);
    return (s inside {W_AH, W_AL, W_DH, W_DL, F_DH, F_DL});
  endfunction

endpackage

// File: rtl/vram_writer_byte_timeout.sv
// Inter-byte idle counter: clears on each byte, pulses expire
// once TIMEOUT byte-less cycles have elapsed inside a frame.
module byte_timeout #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || clr_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_writer.sv
// Decodes framed write/fill commands from a UART byte stream
// and drives the VRAM write port.
module vram_writer
  import vram_pkg::*;
#(
  parameter int unsigned WORDS      = VRAM_WORDS,
  parameter logic [7:0]  SYNC_WRITE = vram_pkg::SYNC_WRITE,
  parameter logic [7:0]  SYNC_FILL  = vram_pkg::SYNC_FILL,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic [VRAM_DW-1:0] VRAM_DATA,
  output logic [VRAM_AW-1:0] VRAM_WRADDR,
  output logic               VRAM_WREN,
  output logic               BUSY,
  output logic               FRAME_ERR
);

  localparam logic [VRAM_AW-1:0] LAST = VRAM_AW'(WORDS - 1);

  wr_state_t          state_q, state_d;
  logic [7:0]         ah_q, ah_d;
  logic [7:0]         al_q, al_d;
  logic [7:0]         dh_q, dh_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [VRAM_DW-1:0] data_q, data_d;
  logic               wren_q, wren_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               tmo;
  logic [VRAM_AW-1:0] wr_addr;
  logic               addr_ok;

  byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .en_i     (mid_frame(state_q)),
    .clr_i    (RX_VALID),
    .expire_o (tmo)
  );

  assign wr_addr = {ah_q[1:0], al_q};
  assign addr_ok = (ah_q[7:2] == 6'd0) && (wr_addr <= LAST);

  always_comb begin
    state_d = state_q;
    ah_d    = ah_q;
    al_d    = al_q;
    dh_d    = dh_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RX_VALID && RX_DATA == SYNC_WRITE) begin
            state_d = W_AH;
          end else if (RX_VALID && RX_DATA == SYNC_FILL) begin
            state_d = F_DH;
          end
        end
        W_AH: begin
          if (RX_VALID) begin
            ah_d    = RX_DATA;
            state_d = W_AL;
          end
        end
        W_AL: begin
          if (RX_VALID) begin
            al_d    = RX_DATA;
            state_d = W_DH;
          end
        end
        W_DH: begin
          if (RX_VALID) begin
            dh_d    = RX_DATA;
            state_d = W_DL;
          end
        end
        W_DL: begin
          if (RX_VALID) begin
            state_d = IDLE;
            if (addr_ok) begin
              wren_d = 1'b1;
              addr_d = wr_addr;
              data_d = {dh_q, RX_DATA};
            end else begin
              err_d = 1'b1;
            end
          end
        end
        F_DH: begin
          if (RX_VALID) begin
            dh_d    = RX_DATA;
            state_d = F_DL;
          end
        end
        F_DL: begin
          if (RX_VALID) begin
            state_d = FILL;
            wren_d  = 1'b1;
            busy_d  = 1'b1;
            addr_d  = '0;
            data_d  = {dh_q, RX_DATA};
          end
        end
        FILL: begin
          // addr_q is the word on the port this cycle
          err_d = RX_VALID;
          if (addr_q == LAST) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
            wren_d = 1'b1;
            busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ah_q    <= '0;
      al_q    <= '0;
      dh_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      dh_q    <= dh_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign VRAM_DATA   = data_q;
  assign VRAM_WRADDR = addr_q;
  assign VRAM_WREN   = wren_q;
  assign BUSY        = busy_q;
  assign FRAME_ERR   = err_q;

endmodule
